// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding
// sequential word request at a time to instruction memory, buffers the
// returned words in a small FIFO and hands {instruction, pc} pairs to decode.
// A redirect flushes the buffer and restarts fetch at the new target; a
// request already in flight is drained and its data discarded.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [31:0]        fetch_pc_reg;
    logic [31:0]        fetch_pc_next;
    logic [31:0]        pend_addr_reg;
    logic [31:0]        pend_addr_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_next;

    logic [31:0]        instr_mem [DEPTH];
    logic [31:0]        pc_mem    [DEPTH];

    logic [31:0]        target_pc;
    logic               push;
    logic               pop;
    logic               space_ok;

    // The low two bits of a redirect target are not meaningful for word fetch.
    assign target_pc = {redirect_pc[31:2], 2'b00};

    // Memory side is a pure decode of registered state so it never glitches
    // within a request; during a drain the stale address is presented.
    assign mem_req  = (state_reg != ST_IDLE);
    assign mem_addr = (state_reg == ST_DRAIN) ? pend_addr_reg : fetch_pc_reg;

    // Decode side: head entry straight from storage, no bypass from memory.
    assign out_valid = (count_reg != '0);
    assign out_instr = instr_mem[rd_ptr_reg];
    assign out_pc    = pc_mem[rd_ptr_reg];

    // A redirect overrides both FIFO ports; only a live REQ ack is pushed.
    assign push = (state_reg == ST_REQ) && mem_ack && !redirect;
    assign pop  = out_valid && out_ready && !redirect;

    // Occupancy and pointer update including this cycle's push, pop and flush.
    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (redirect) begin
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // A new request is only worth issuing if its word will have a slot.
    assign space_ok = (count_next < DEPTH_CNT);

    // Fetch FSM next-state, fetch PC and pending (drained) address.
    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        pend_addr_next = pend_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                // mem_ack is ignored here: no request is outstanding.
                if (redirect) begin
                    fetch_pc_next = target_pc;
                end
                if (space_ok) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    fetch_pc_next = target_pc;
                    if (!mem_ack) begin
                        // Request still in flight: hold its address until acked.
                        pend_addr_next = fetch_pc_reg;
                        state_next     = ST_DRAIN;
                    end
                end else if (mem_ack) begin
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                    state_next    = space_ok ? ST_REQ : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    fetch_pc_next = target_pc;
                end
                if (mem_ack) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            fetch_pc_reg  <= RESET_PC;
            pend_addr_reg <= RESET_PC;
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            fetch_pc_reg  <= fetch_pc_next;
            pend_addr_reg <= pend_addr_next;
            count_reg     <= count_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
        end
    end

    // FIFO storage: one slot per entry, written when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            // Slot gi captures the acked word and the address it was fetched from.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    instr_mem[gi] <= '0;
                    pc_mem[gi]    <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    instr_mem[gi] <= mem_rdata;
                    pc_mem[gi]    <= fetch_pc_reg;
                end
            end
        end
    endgenerate

endmodule
